decod_arb_rr: RTL and testbench

- Round-robin arbiter and sequencer that shares one 4-to-6 inverse decoder (Y = 15 - A) among N_REQ requesters.
- Each requester presents a 4-bit code with a request. The block grants one requester at a time, decodes its code, and presents the 6-bit result with the requester ID on a valid/ready output.
- Sits between multiple control sources (e.g. switch/key scanners) and the display/ALU datapath that consumes decoded values.

---
 rtl/decod_pkg.sv | 37 +++
 rtl/decod_inv4x6.sv | 12 +
 rtl/decod_arb_rr.sv | 114 +++++++++++
 tb/tb_decod_arb_rr.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/decod_pkg.sv
// Shared definitions for the decod_arb_rr slice: data widths, the reset value
// of the decoded output, the output FSM state type and the round-robin pick helper.
package decod_pkg;

    localparam int         CODE_W  = 4;
    localparam int         Y_W     = 6;
    localparam logic [5:0] Y_RESET = 6'b111111;
    localparam int         MAX_REQ = 8;

    // Output register occupancy.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // One-hot pick of the first asserted request at or after ptr, wrapping upward.
    // Requests are zero-padded to MAX_REQ bits. Padded positions are never set,
    // so the mod-8 walk visits the real requesters in the same order as a
    // mod-N_REQ walk would.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                   input logic [2:0]         ptr);
        logic [MAX_REQ-1:0] g;
        logic               found;
        logic [2:0]         idx;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = ptr + 3'(k);
            if (req[idx] && !found) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/decod_inv4x6.sv
// Combinational 4-bit to 6-bit inverse decoder: y = 15 - a, zero-extended.
module decod_inv4x6
    import decod_pkg::*;
(
    input  logic [CODE_W-1:0] a,
    output logic [Y_W-1:0]    y
);

    // 15 - a over four bits is the bitwise complement; upper bits are zero.
    assign y = {2'b00, ~a};

endmodule

// File: rtl/decod_arb_rr.sv
// Round-robin arbiter sharing one inverse decoder among N_REQ requesters.
// The winner's code is decoded into a one-entry output register with a
// valid/ready handshake.
// Build option: define DECOD_ARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins, no rotating pointer); the default build is round-robin.
//
// Handshake: y/y_id are transferred at a rising edge where y_valid && y_ready.
// While y_valid is high and y_ready is low, y, y_id and y_valid hold and no
// grant is issued. A grant is issued only when the output register is empty
// or is being drained in the same cycle.
module decod_arb_rr
    import decod_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [4*N_REQ-1:0]    code,
    output logic [N_REQ-1:0]      gnt,
    output logic [Y_W-1:0]        y,
    output logic [ID_W-1:0]       y_id,
    output logic                  y_valid,
    input  logic                  y_ready
);

    state_t               state_q, state_d;
    logic                 acc;
    logic [2:0]           ptr3;
    logic [MAX_REQ-1:0]   pick;
    logic [ID_W-1:0]      win_id;
    logic [CODE_W-1:0]    win_code;
    logic [Y_W-1:0]       dec_y;

`ifdef DECOD_ARB_FIXED_PRIO_EN
    // Fixed priority is a round-robin search that always starts at index 0.
    assign ptr3 = 3'd0;
`else
    logic [ID_W-1:0]      rr_ptr;

    assign ptr3 = 3'(rr_ptr);

    // Pointer moves to the slot just after the latest winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (|gnt) begin
            rr_ptr <= (win_id == ID_W'(N_REQ-1)) ? '0 : win_id + 1'b1;
        end
    end
`endif

    assign acc  = (state_q == EMPTY) || y_ready;
    assign pick = rr_pick(MAX_REQ'(req), ptr3);
    assign gnt  = (rst || !acc) ? '0 : pick[N_REQ-1:0];

    generate
        if (N_REQ < MAX_REQ) begin : g_pad
            logic unused_pick;
            assign unused_pick = |pick[MAX_REQ-1:N_REQ];
        end
    endgenerate

    // Encode the one-hot grant and select the winner's code.
    always_comb begin
        win_id   = '0;
        win_code = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                win_id   = ID_W'(i);
                win_code = code[4*i +: 4];
            end
        end
    end

    decod_inv4x6 u_inv (
        .a (win_code),
        .y (dec_y)
    );

    // Output FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a grant fills the register, a consume without grant empties it.
    always_comb begin
        state_d = state_q;
        if (|gnt) begin
            state_d = FULL;
        end else if ((state_q == FULL) && y_ready) begin
            state_d = EMPTY;
        end
    end

    // Output data register, loaded only on a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            y    <= Y_RESET;
            y_id <= '0;
        end else if (|gnt) begin
            y    <= dec_y;
            y_id <= win_id;
        end
    end

    assign y_valid = (state_q == FULL);

endmodule

// File: tb/tb_decod_arb_rr.sv
// Directed bench for decod_arb_rr (N_REQ=4) with hand-computed expected values.
// Compile with DECOD_ARB_FIXED_PRIO_EN defined to check the fixed-priority build.
module tb_decod_arb_rr;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic               clk;
    logic               rst;
    logic [N_REQ-1:0]   req;
    logic [4*N_REQ-1:0] code;
    logic [N_REQ-1:0]   gnt;
    logic [5:0]         y;
    logic [ID_W-1:0]    y_id;
    logic               y_valid;
    logic               y_ready;

    int n_cmp;
    int n_err;

    decod_arb_rr #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .code    (code),
        .gnt     (gnt),
        .y       (y),
        .y_id    (y_id),
        .y_valid (y_valid),
        .y_ready (y_ready)
    );

    // Clock and reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_code(input int idx, input logic [3:0] c);
        code[4*idx +: 4] = c;
    endtask

    task automatic check_out(input string tag, input logic [5:0] ey, input logic [1:0] eid);
        check({tag, ".y"},     32'(y),       32'(ey));
        check({tag, ".y_id"},  32'(y_id),    32'(eid));
        check({tag, ".valid"}, 32'(y_valid), 32'd1);
    endtask

    int rr_exp[5];
    logic [5:0] rr_y[4];

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst     = 1'b1;
        req     = 4'b1111;
        code    = '0;
        y_ready = 1'b1;

        // Reset holds everything idle even with all requests up.
        for (int c = 0; c < 2; c++) begin
            tick();
            check("rst.gnt",   32'(gnt),     32'd0);
            check("rst.valid", 32'(y_valid), 32'd0);
            check("rst.y",     32'(y),       32'h3f);
        end

        // Round robin: codes {0,5,10,15} -> y {15,10,5,0}.
        rst = 1'b0;
        set_code(0, 4'd0);
        set_code(1, 4'd5);
        set_code(2, 4'd10);
        set_code(3, 4'd15);
        rr_y[0] = 6'd15; rr_y[1] = 6'd10; rr_y[2] = 6'd5; rr_y[3] = 6'd0;
`ifdef DECOD_ARB_FIXED_PRIO_EN
        rr_exp = '{0, 0, 0, 0, 0};
`else
        rr_exp = '{0, 1, 2, 3, 0};
`endif
        #1;
        for (int k = 0; k < 5; k++) begin
            check("rr.gnt", 32'(gnt), 32'(1) << rr_exp[k]);
            tick();
            check_out("rr", rr_y[rr_exp[k]], 2'(rr_exp[k]));
        end

        // Idle with ready: the register drains.
        req = 4'b0000;
        #1;
        check("idle.gnt", 32'(gnt), 32'd0);
        tick();
        check("idle.valid", 32'(y_valid), 32'd0);

        // Single request: code2=3 -> y=12, id=2.
        req = 4'b0100;
        set_code(2, 4'd3);
        #1;
        check("single.gnt", 32'(gnt), 32'b0100);
        tick();
        check_out("single", 6'd12, 2'd2);
        req = 4'b0000;
        tick();
        check("single.drain", 32'(y_valid), 32'd0);

        // Backpressure: load y=7 from requester 1, then stall three cycles.
        req = 4'b0010;
        set_code(1, 4'd8);
        #1;
        check("bp.load.gnt", 32'(gnt), 32'b0010);
        tick();
        check_out("bp.load", 6'd7, 2'd1);
        y_ready = 1'b0;
        set_code(1, 4'd2);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp.stall.gnt", 32'(gnt), 32'd0);
            tick();
            check_out("bp.stall", 6'd7, 2'd1);
        end
        // Release: same-cycle consume and grant, no bubble.
        y_ready = 1'b1;
        #1;
        check("bp.release.gnt", 32'(gnt), 32'b0010);
        tick();
        check_out("bp.release", 6'd13, 2'd1);

        // Wrap: winner 3 returns the pointer to 0.
        req = 4'b1000;
        set_code(3, 4'd6);
        #1;
        check("wrap.gnt", 32'(gnt), 32'b1000);
        tick();
        check_out("wrap", 6'd9, 2'd3);

        // Reset mid-stream with a full register: grant suppressed, output cleared.
        rst     = 1'b1;
        req     = 4'b1010;
        y_ready = 1'b0;
        #1;
        check("midrst.gnt", 32'(gnt), 32'd0);
        tick();
        check("midrst.valid", 32'(y_valid), 32'd0);
        check("midrst.y",     32'(y),       32'h3f);
        rst = 1'b0;
        set_code(1, 4'd4);
        #1;
        check("postrst.gnt", 32'(gnt), 32'b0010);
        tick();
        check_out("postrst", 6'd11, 2'd1);

        // Pointer now 2: reset must return it to 0 so index 1 beats index 3.
        y_ready = 1'b1;
        rst     = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1010;
        #1;
        check("ptrrst.gnt", 32'(gnt), 32'b0010);
        tick();
        check_out("ptrrst", 6'd11, 2'd1);

        // Lone requester wins on consecutive cycles.
        req = 4'b0001;
        set_code(0, 4'd1);
        for (int c = 0; c < 2; c++) begin
            #1;
            check("lone.gnt", 32'(gnt), 32'b0001);
            tick();
            check_out("lone", 6'd14, 2'd0);
        end
        req = 4'b0000;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
